// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch ops, serial 1-bit-per-cycle shifter.
// One request in flight at a time; the result is held in DONE until the consumer takes it.
module alu_iterative_exec #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  BranchTaken
);
   localparam int SHW = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_BNE = 4'b0100;
   localparam logic [3:0] OP_BLT = 4'b0101;
   localparam logic [3:0] OP_BGE = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_SRL = 4'b1011;
   localparam logic [3:0] OP_SLL = 4'b1100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [3:0]            op_reg;
   logic [DATA_WIDTH-1:0] work_reg;
   logic [SHW-1:0]        count;
   logic [SHW-1:0]        shamt;
   logic                  accept;
   logic                  is_shift;
   logic [DATA_WIDTH-1:0] comb_result;
   logic                  comb_cond;
   logic [DATA_WIDTH-1:0] shifted;

   assign shamt    = SrcB[SHW-1:0];
   assign accept   = in_valid && (state == IDLE);
   assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

   // Single-cycle function unit; undefined codes fall to the zero default.
   always_comb begin
      comb_result = '0;
      comb_cond   = 1'b0;
      case (Operation)
         OP_AND: comb_result = SrcA & SrcB;
         OP_OR:  comb_result = SrcA | SrcB;
         OP_XOR: comb_result = SrcA ^ SrcB;
         OP_ADD: comb_result = SrcA + SrcB;
         OP_SUB: comb_result = SrcA - SrcB;
         OP_SLT: comb_result[0] = $signed(SrcA) < $signed(SrcB);
         OP_BEQ: comb_cond = (SrcA == SrcB);
         OP_BNE: comb_cond = (SrcA != SrcB);
         OP_BLT: comb_cond = $signed(SrcA) < $signed(SrcB);
         OP_BGE: comb_cond = $signed(SrcA) >= $signed(SrcB);
         default: comb_result = '0;
      endcase
      if (comb_cond) begin
         comb_result[0] = 1'b1;
      end
   end

   // One-bit step of the serial shifter, direction chosen by the latched op.
   always_comb begin
      shifted = work_reg;
      case (op_reg)
         OP_SLL:  shifted = {work_reg[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, work_reg[DATA_WIDTH-1:1]};
         OP_SRA:  shifted = {work_reg[DATA_WIDTH-1], work_reg[DATA_WIDTH-1:1]};
         default: shifted = work_reg;
      endcase
   end

   // Zero-length shifts skip SHIFT, and the final shift step lands directly in DONE,
   // so a shift by n finishes n cycles after the single-cycle ops would.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_shift && (shamt != '0)) begin
                  state_next = SHIFT;
               end else begin
                  state_next = DONE;
               end
            end
         end
         SHIFT: begin
            if (count == SHW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand latch, shifter working register and the held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg      <= '0;
         work_reg    <= '0;
         count       <= '0;
         ALUResult   <= '0;
         BranchTaken <= 1'b0;
      end else if (accept) begin
         op_reg <= Operation;
         if (is_shift) begin
            work_reg    <= SrcA;
            count       <= shamt;
            BranchTaken <= 1'b0;
            if (shamt == '0) begin
               ALUResult <= SrcA;
            end
         end else begin
            ALUResult   <= comb_result;
            BranchTaken <= comb_cond;
         end
      end else if (state == SHIFT) begin
         work_reg <= shifted;
         count    <= count - SHW'(1);
         if (count == SHW'(1)) begin
            ALUResult <= shifted;
         end
      end
   end
endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec: hand-computed results, latencies, reset abort and backpressure.
module tb_alu_iterative_exec;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        BranchTaken;

   int checks = 0;
   int errors = 0;
   int lat;

   alu_iterative_exec #(.DATA_WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .Operation(Operation),
      .SrcA(SrcA),
      .SrcB(SrcB),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ALUResult(ALUResult),
      .BranchTaken(BranchTaken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents one request, returns cycles from the accept edge (counted as 1) to out_valid.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int cycles);
      @(negedge clk);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      SrcA      = ~a;
      SrcB      = 32'h0000_001F;
      Operation = 4'b0011;
      cycles    = 1;
      while (!out_valid && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic releaseOutput(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_rel_out_valid"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, "_rel_in_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expResult, input logic expBranch, input int expLat);
      int cyc;
      applyStimulus(op, a, b, cyc);
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(expLat));
      checkOutput({tag, "_result"}, ALUResult, expResult);
      checkOutput({tag, "_branch"}, {31'b0, BranchTaken}, {31'b0, expBranch});
      releaseOutput(tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      Operation = 4'b0000;
      SrcA      = '0;
      SrcB      = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_result", ALUResult, 32'd0);
      checkOutput("reset_branch", {31'b0, BranchTaken}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      runOp("sub", 4'b1001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);

      // Reset in the middle of a 20-bit left shift
      @(negedge clk);
      Operation = 4'b1100;
      SrcA      = 32'h0000_0001;
      SrcB      = 32'd20;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("midshift_busy", {31'b0, in_ready}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midshift_no_valid", {31'b0, out_valid}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("abort_result", ALUResult, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      runOp("add_wrap", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
      runOp("slt", 4'b0111, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1);
      runOp("sra4", 4'b1010, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 5);
      runOp("srl4", 4'b1011, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 5);
      runOp("sll31", 4'b1100, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 32);
      runOp("sll0", 4'b1100, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1);
      runOp("sra_hi_ignored", 4'b1010, 32'h8000_0010, 32'h0000_0024, 32'hF800_0001, 1'b0, 5);
      runOp("beq", 4'b1000, 32'd3, 32'd3, 32'd1, 1'b1, 1);
      runOp("and", 4'b0000, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 1'b0, 1);
      runOp("bne", 4'b0100, 32'd3, 32'd3, 32'd0, 1'b0, 1);
      runOp("blt", 4'b0101, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 1);
      runOp("bge", 4'b0110, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1);
      runOp("or", 4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
      runOp("xor", 4'b0010, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1);

      // Backpressure: result must hold while a second request is presented and ignored
      applyStimulus(4'b0011, 32'd10, 32'd20, lat);
      checkOutput("bp_latency", 32'(lat), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            Operation = 4'b1001;
            SrcA      = 32'd100;
            SrcB      = 32'd1;
            in_valid  = 1'b1;
         end
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp_out_valid_%0d", i), {31'b0, out_valid}, 32'd1);
         checkOutput($sformatf("bp_result_%0d", i), ALUResult, 32'd30);
         checkOutput($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      releaseOutput("bp");
      @(posedge clk);
      #1;
      checkOutput("bp_not_queued_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("bp_not_queued_result", ALUResult, 32'd30);

      runOp("beq_pre_undef", 4'b1000, 32'd7, 32'd7, 32'd1, 1'b1, 1);
      runOp("undef_1111", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
